// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage in front of the register file's single write port.
// Merges the never-stalled memory/load path with the buffered ALU path,
// registers exception/iret events, and forwards results still in flight.
// Optional feature macro: WB_ZERO_REG_EN (register 0 hard-wired to zero).
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_dest,
  input  logic [DW-1:0]            alu_data,
  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_dest,
  input  logic [DW-1:0]            mem_data,
  input  logic                     xcpt_in_valid,
  input  logic [2:0]               xcpt_in_type,
  input  logic [DW-1:0]            xcpt_in_pc,
  input  logic [DW-1:0]            xcpt_in_addr,
  input  logic                     iret_in,
  output logic                     rf_writeEn,
  output logic [AW-1:0]            rf_dest_addr,
  output logic [DW-1:0]            rf_writeVal,
  output logic                     rf_xcpt_valid,
  output logic [2:0]               rf_xcpt_type,
  output logic [DW-1:0]            rf_rmPC,
  output logic [DW-1:0]            rf_rmAddr,
  output logic                     rf_iret,
  input  logic [AW-1:0]            fwd1_addr,
  input  logic [AW-1:0]            fwd2_addr,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DW-1:0]            fwd1_data,
  output logic [DW-1:0]            fwd2_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // ALU result FIFO storage (kept in flops: forwarding searches every entry)
  logic [AW-1:0] fifo_dest_q [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          rf_writeEn_q, rf_writeEn_d;
  logic [AW-1:0] rf_dest_addr_q, rf_dest_addr_d;
  logic [DW-1:0] rf_writeVal_q, rf_writeVal_d;
  logic          rf_xcpt_valid_q;
  logic [2:0]    rf_xcpt_type_q;
  logic [DW-1:0] rf_rmPC_q;
  logic [DW-1:0] rf_rmAddr_q;
  logic          rf_iret_q;

  logic alu_acc;
  logic alu_live;
  logic mem_live;
  logic fifo_empty;
  logic push;
  logic pop;

  assign alu_ready  = (count_q < CW'(DEPTH));
  assign alu_acc    = alu_valid & alu_ready;
  assign fifo_empty = (count_q == '0);

`ifdef WB_ZERO_REG_EN
  // Results targeting register 0 are accepted but discarded
  assign alu_live = alu_acc & (alu_dest != '0);
  assign mem_live = mem_valid & (mem_dest != '0);
`else
  assign alu_live = alu_acc;
  assign mem_live = mem_valid;
`endif

  // Write-slot selection: mem, then FIFO head, then ALU bypass; exception drops all
  always_comb begin
    push           = 1'b0;
    pop            = 1'b0;
    rf_writeEn_d   = 1'b0;
    rf_dest_addr_d = rf_dest_addr_q;
    rf_writeVal_d  = rf_writeVal_q;
    if (!xcpt_in_valid) begin
      if (mem_valid) begin
        rf_writeEn_d = mem_live;
        if (mem_live) begin
          rf_dest_addr_d = mem_dest;
          rf_writeVal_d  = mem_data;
        end
        push = alu_live;
      end else if (!fifo_empty) begin
        pop            = 1'b1;
        rf_writeEn_d   = 1'b1;
        rf_dest_addr_d = fifo_dest_q[rd_ptr_q];
        rf_writeVal_d  = fifo_data_q[rd_ptr_q];
        push           = alu_live;
      end else if (alu_live) begin
        rf_writeEn_d   = 1'b1;
        rf_dest_addr_d = alu_dest;
        rf_writeVal_d  = alu_data;
      end
    end
  end

  // FIFO pointer/count next state; an exception flushes everything queued
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (xcpt_in_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // FIFO control and writeback output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      rf_writeEn_q    <= 1'b0;
      rf_dest_addr_q  <= '0;
      rf_writeVal_q   <= '0;
      rf_xcpt_valid_q <= 1'b0;
      rf_xcpt_type_q  <= '0;
      rf_rmPC_q       <= '0;
      rf_rmAddr_q     <= '0;
      rf_iret_q       <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      rf_writeEn_q    <= rf_writeEn_d;
      rf_dest_addr_q  <= rf_dest_addr_d;
      rf_writeVal_q   <= rf_writeVal_d;
      rf_xcpt_valid_q <= xcpt_in_valid;
      rf_xcpt_type_q  <= xcpt_in_valid ? xcpt_in_type : 3'd0;
      rf_rmPC_q       <= xcpt_in_valid ? xcpt_in_pc : '0;
      rf_rmAddr_q     <= xcpt_in_valid ? xcpt_in_addr : '0;
      rf_iret_q       <= iret_in & ~xcpt_in_valid;
    end
  end

  // FIFO payload storage; contents are qualified by count, so no reset needed
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_dest_q[wr_ptr_q] <= alu_dest;
      fifo_data_q[wr_ptr_q] <= alu_data;
    end
  end

  // Forwarding lookup, one instance per decode operand
  logic [AW-1:0] fwd_addr [2];
  assign fwd_addr[0] = fwd1_addr;
  assign fwd_addr[1] = fwd2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic          hit;
    logic [DW-1:0] data;

    // Output register first, then FIFO oldest->youngest so the youngest match wins
    always_comb begin
      logic [PW-1:0] idx;
      idx  = '0;
      hit  = 1'b0;
      data = '0;
      if (rf_writeEn_q && (rf_dest_addr_q == fwd_addr[gi])) begin
        hit  = 1'b1;
        data = rf_writeVal_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if ((CW'(i) < count_q) && (fifo_dest_q[idx] == fwd_addr[gi])) begin
          hit  = 1'b1;
          data = fifo_data_q[idx];
        end
      end
`ifdef WB_ZERO_REG_EN
      if (fwd_addr[gi] == '0) begin
        hit  = 1'b1;
        data = '0;
      end
`endif
    end
  end

  assign fwd1_hit  = g_fwd[0].hit;
  assign fwd1_data = g_fwd[0].data;
  assign fwd2_hit  = g_fwd[1].hit;
  assign fwd2_data = g_fwd[1].data;

  assign occupancy     = count_q;
  assign rf_writeEn    = rf_writeEn_q;
  assign rf_dest_addr  = rf_dest_addr_q;
  assign rf_writeVal   = rf_writeVal_q;
  assign rf_xcpt_valid = rf_xcpt_valid_q;
  assign rf_xcpt_type  = rf_xcpt_type_q;
  assign rf_rmPC       = rf_rmPC_q;
  assign rf_rmAddr     = rf_rmAddr_q;
  assign rf_iret       = rf_iret_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus with scoreboard queues for register-file
// writes, exception pulses and iret pulses; a negedge monitor pops and compares.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_dest;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] mem_data;
  logic          xcpt_in_valid;
  logic [2:0]    xcpt_in_type;
  logic [DW-1:0] xcpt_in_pc, xcpt_in_addr;
  logic          iret_in;
  logic          rf_writeEn;
  logic [AW-1:0] rf_dest_addr;
  logic [DW-1:0] rf_writeVal;
  logic          rf_xcpt_valid;
  logic [2:0]    rf_xcpt_type;
  logic [DW-1:0] rf_rmPC, rf_rmAddr;
  logic          rf_iret;
  logic [AW-1:0] fwd1_addr, fwd2_addr;
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;
  logic [$clog2(DEPTH):0] occupancy;

  wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .xcpt_in_valid(xcpt_in_valid), .xcpt_in_type(xcpt_in_type),
    .xcpt_in_pc(xcpt_in_pc), .xcpt_in_addr(xcpt_in_addr), .iret_in(iret_in),
    .rf_writeEn(rf_writeEn), .rf_dest_addr(rf_dest_addr), .rf_writeVal(rf_writeVal),
    .rf_xcpt_valid(rf_xcpt_valid), .rf_xcpt_type(rf_xcpt_type),
    .rf_rmPC(rf_rmPC), .rf_rmAddr(rf_rmAddr), .rf_iret(rf_iret),
    .fwd1_addr(fwd1_addr), .fwd2_addr(fwd2_addr),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [2:0]    typ;
    logic [DW-1:0] pc;
    logic [DW-1:0] addr;
  } xc_t;

  wr_t wr_q[$];
  xc_t xc_q[$];
  int  iret_q[$];

  int checks = 0;
  int errors = 0;

  wr_t mon_w;
  xc_t mon_x;
  int  mon_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic exp_wr(input logic [AW-1:0] d, input logic [DW-1:0] v);
    wr_t e;
    e.dest = d;
    e.data = v;
    wr_q.push_back(e);
  endtask

  task automatic exp_xc(input logic [2:0] t, input logic [DW-1:0] pc, input logic [DW-1:0] ad);
    xc_t e;
    e.typ  = t;
    e.pc   = pc;
    e.addr = ad;
    xc_q.push_back(e);
  endtask

  // Monitor: every presented write / exception / iret pulse must match the next expected one
  always @(negedge clock) begin
    if (rf_writeEn === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: got dest=%0d data=0x%08h expected no write", rf_dest_addr, rf_writeVal);
      end else begin
        mon_w = wr_q.pop_front();
        if (rf_dest_addr !== mon_w.dest || rf_writeVal !== mon_w.data) begin
          errors++;
          $display("FAIL rf_write: got dest=%0d data=0x%08h expected dest=%0d data=0x%08h",
                   rf_dest_addr, rf_writeVal, mon_w.dest, mon_w.data);
        end else
          $display("write dest=%0d data=0x%08h ok", rf_dest_addr, rf_writeVal);
      end
    end
    if (rf_xcpt_valid === 1'b1) begin
      checks++;
      if (xc_q.size() == 0) begin
        errors++;
        $display("FAIL rf_xcpt: got type=%0d pc=0x%0h expected no exception", rf_xcpt_type, rf_rmPC);
      end else begin
        mon_x = xc_q.pop_front();
        if (rf_xcpt_type !== mon_x.typ || rf_rmPC !== mon_x.pc || rf_rmAddr !== mon_x.addr) begin
          errors++;
          $display("FAIL rf_xcpt: got type=%0d pc=0x%0h addr=0x%0h expected type=%0d pc=0x%0h addr=0x%0h",
                   rf_xcpt_type, rf_rmPC, rf_rmAddr, mon_x.typ, mon_x.pc, mon_x.addr);
        end else
          $display("xcpt type=%0d pc=0x%0h addr=0x%0h ok", rf_xcpt_type, rf_rmPC, rf_rmAddr);
      end
    end
    if (rf_iret === 1'b1) begin
      checks++;
      if (iret_q.size() == 0) begin
        errors++;
        $display("FAIL rf_iret: got 1 expected 0");
      end else begin
        mon_i = iret_q.pop_front();
        $display("iret pulse %0d ok", mon_i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset = 1'b1;
    alu_valid = 0; alu_dest = '0; alu_data = '0;
    mem_valid = 0; mem_dest = '0; mem_data = '0;
    xcpt_in_valid = 0; xcpt_in_type = '0; xcpt_in_pc = '0; xcpt_in_addr = '0;
    iret_in = 0; fwd1_addr = '0; fwd2_addr = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    cyc();
    chk("reset_occupancy", 64'(occupancy), 0);
    chk("reset_writeEn", 64'(rf_writeEn), 0);
    chk("reset_dest", 64'(rf_dest_addr), 0);
    chk("reset_val", 64'(rf_writeVal), 0);
    chk("reset_xcpt", 64'(rf_xcpt_valid), 0);
    chk("reset_iret", 64'(rf_iret), 0);
    chk("reset_ready", 64'(alu_ready), 1);

    // Single ALU write with empty FIFO goes straight through
    alu_valid = 1; alu_dest = 5'd3; alu_data = 32'hA5A5_0001;
    exp_wr(5'd3, 32'hA5A5_0001);
    cyc();
    alu_valid = 0;
    chk("single_occupancy", 64'(occupancy), 0);

    // Contention: mem wins 5 cycles, ALU fills FIFO
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1; mem_dest = AW'(10 + i); mem_data = 32'h1000 + i;
      alu_valid = 1; alu_dest = AW'(i + 1); alu_data = 32'h200 + i + 1;
      exp_wr(AW'(10 + i), 32'h1000 + i);
      chk("cont_ready", 64'(alu_ready), (i < 4) ? 1 : 0);
      chk("cont_occupancy", 64'(occupancy), i);
      cyc();
    end
    mem_valid = 0;
    for (int i = 1; i <= 5; i++) exp_wr(AW'(i), 32'h200 + i);
    chk("cont_full_occ", 64'(occupancy), 4);
    k = 0;
    while (!alu_ready && k < 10) begin
      cyc();
      k++;
    end
    chk("cont_ready_return", 64'(alu_ready), 1);
    cyc();
    alu_valid = 0;
    repeat (6) cyc();
    chk("cont_drained", 64'(occupancy), 0);

    // Forwarding: two FIFO entries for dest 7, youngest wins; output register also searched
    mem_valid = 1; mem_dest = 5'd20; mem_data = 32'h3000;
    alu_valid = 1; alu_dest = 5'd7; alu_data = 32'h11;
    exp_wr(5'd20, 32'h3000);
    cyc();
    mem_dest = 5'd21; mem_data = 32'h3001; alu_data = 32'h22;
    exp_wr(5'd21, 32'h3001);
    cyc();
    mem_dest = 5'd22; mem_data = 32'h3002; alu_valid = 0;
    exp_wr(5'd22, 32'h3002);
    fwd1_addr = 5'd7; fwd2_addr = 5'd9;
    #1;
    chk("fwd1_hit", 64'(fwd1_hit), 1);
    chk("fwd1_data", 64'(fwd1_data), 64'h22);
    chk("fwd2_miss_hit", 64'(fwd2_hit), 0);
    chk("fwd2_miss_data", 64'(fwd2_data), 0);
    fwd1_addr = 5'd20; fwd2_addr = 5'd21;
    #1;
    chk("fwd1_stale_hit", 64'(fwd1_hit), 0);
    chk("fwd2_outreg_hit", 64'(fwd2_hit), 1);
    chk("fwd2_outreg_data", 64'(fwd2_data), 64'h3001);
    cyc();
    mem_valid = 0;
    exp_wr(5'd7, 32'h11);
    exp_wr(5'd7, 32'h22);
    repeat (4) cyc();
    chk("fwd_drained", 64'(occupancy), 0);

    // Exception flush with occupancy 3 and a concurrent mem write
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_dest = AW'(24 + i); mem_data = 32'h4000 + i;
      alu_valid = 1; alu_dest = AW'(i + 1); alu_data = 32'h401 + i;
      exp_wr(AW'(24 + i), 32'h4000 + i);
      cyc();
    end
    alu_valid = 0;
    chk("xcpt_pre_occ", 64'(occupancy), 3);
    mem_dest = 5'd27; mem_data = 32'hDEAD;
    xcpt_in_valid = 1; xcpt_in_type = 3'd2; xcpt_in_pc = 32'h100; xcpt_in_addr = 32'h2000;
    exp_xc(3'd2, 32'h100, 32'h2000);
    cyc();
    xcpt_in_valid = 0; mem_valid = 0;
    chk("xcpt_writeEn", 64'(rf_writeEn), 0);
    chk("xcpt_valid", 64'(rf_xcpt_valid), 1);
    chk("xcpt_occ", 64'(occupancy), 0);
    repeat (3) cyc();
    chk("xcpt_pulse_end", 64'(rf_xcpt_valid), 0);

    // Exception beats iret; then iret alone
    xcpt_in_valid = 1; xcpt_in_type = 3'd5; xcpt_in_pc = 32'h44; xcpt_in_addr = 32'h88; iret_in = 1;
    exp_xc(3'd5, 32'h44, 32'h88);
    cyc();
    xcpt_in_valid = 0;
    chk("xi_iret", 64'(rf_iret), 0);
    chk("xi_xcpt", 64'(rf_xcpt_valid), 1);
    iret_q.push_back(1);
    cyc();
    iret_in = 0;
    chk("iret_alone", 64'(rf_iret), 1);
    cyc();
    chk("iret_pulse_end", 64'(rf_iret), 0);

    // Reset mid-drain discards queued ALU results
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1; mem_dest = AW'(28 + i); mem_data = 32'h5000 + i;
      alu_valid = 1; alu_dest = AW'(11 + i); alu_data = 32'h501 + i;
      exp_wr(AW'(28 + i), 32'h5000 + i);
      cyc();
    end
    mem_valid = 0; alu_valid = 0;
    chk("rst_pre_occ", 64'(occupancy), 2);
    reset = 1;
    cyc();
    reset = 0;
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_writeEn", 64'(rf_writeEn), 0);
    chk("rst_dest", 64'(rf_dest_addr), 0);
    chk("rst_val", 64'(rf_writeVal), 0);
    chk("rst_xcpt", 64'(rf_xcpt_valid), 0);
    chk("rst_iret", 64'(rf_iret), 0);
    chk("rst_ready", 64'(alu_ready), 1);
    repeat (4) cyc();
    chk("rst_post_occ", 64'(occupancy), 0);

    chk("wr_queue_empty", 64'(wr_q.size()), 0);
    chk("xcpt_queue_empty", 64'(xc_q.size()), 0);
    chk("iret_queue_empty", 64'(iret_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
